move_ctrl: RTL

MOVE_CTRL -- requirements
Module: move_ctrl

---
 rtl/move_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/move_ctrl.sv
// Grid movement controller: key arbitration, direction commit on step ticks,
// toroidal head position and IDLE/RUN/PAUSE/DEAD game-state sequencing.
module move_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 12,
  parameter int X_INIT   = 8,
  parameter int Y_INIT   = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       L,
  input  logic       R,
  input  logic       U,
  input  logic       D,
  input  logic       pause,
  input  logic       collide,
  input  logic       restart,
  output logic [1:0] dir,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic       step,
  output logic [1:0] state
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [5:0] XI   = 6'(X_INIT);
  localparam logic [5:0] YI   = 6'(Y_INIT);
  localparam logic [5:0] XMAX = 6'(GRID_W - 1);
  localparam logic [5:0] YMAX = 6'(GRID_H - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DEAD  = 2'b11;

  localparam logic [1:0] DIR_U = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_L = 2'b10;
  localparam logic [1:0] DIR_R = 2'b11;

  logic [1:0]    pending;
  logic [CW-1:0] cnt;

  logic       key_any;
  logic [1:0] key_dir;
  logic       key_ok;
  logic [1:0] pend_nxt;
  logic [5:0] nxt_x;
  logic [5:0] nxt_y;

  // Fixed priority U > D > L > R; only the winner is ever considered.
  always_comb begin
    key_any = U | D | L | R;
    if (U)      key_dir = DIR_U;
    else if (D) key_dir = DIR_D;
    else if (L) key_dir = DIR_L;
    else        key_dir = DIR_R;
    // Opposite pairs differ only in bit 0; check against committed dir.
    key_ok   = key_any && (key_dir != {dir[1], ~dir[0]});
    pend_nxt = key_ok ? key_dir : pending;
  end

  always_comb begin
    nxt_x = head_x;
    nxt_y = head_y;
    case (pending)
      DIR_U: nxt_y = (head_y == '0)   ? YMAX : head_y - 6'd1;
      DIR_D: nxt_y = (head_y == YMAX) ? '0   : head_y + 6'd1;
      DIR_L: nxt_x = (head_x == '0)   ? XMAX : head_x - 6'd1;
      default: nxt_x = (head_x == XMAX) ? '0 : head_x + 6'd1;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      head_x  <= XI;
      head_y  <= YI;
      dir     <= DIR_R;
      pending <= DIR_R;
      cnt     <= '0;
      step    <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_any) begin
            state   <= ST_RUN;
            dir     <= key_dir;
            pending <= key_dir;
            cnt     <= '0;
          end
        end
        ST_RUN: begin
          if (collide) begin
            state <= ST_DEAD;
          end else if (pause) begin
            state <= ST_PAUSE;
          end else begin
            // A key accepted on a step tick targets the next step.
            pending <= pend_nxt;
            if (cnt == CNT_LAST) begin
              cnt    <= '0;
              dir    <= pending;
              head_x <= nxt_x;
              head_y <= nxt_y;
              step   <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (pause) state <= ST_RUN;
        end
        default: begin
          if (restart) begin
            state   <= ST_IDLE;
            head_x  <= XI;
            head_y  <= YI;
            dir     <= DIR_R;
            pending <= DIR_R;
            cnt     <= '0;
          end
        end
      endcase
    end
  end

endmodule
